// File: rtl/plc_io_scan.sv
// ============================================================================
// Module   : plc_io_scan
// Purpose  : PLC I/O image block - debounced inputs, frozen analog images,
//            double-buffered outputs and a scan watchdog behind a register port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module plc_io_scan #(
    parameter int              DIN_N   = 4,
    parameter int              DOUT_N  = 4,
    parameter int              AIN_N   = 1,
    parameter int              AW      = 16,
    parameter int              DEB_CYC = 4,
    parameter logic [AW-1:0]   HI_LIM  = 16'd100,
    parameter logic [AW-1:0]   LO_LIM  = 16'd90,
    parameter int              WDT_CYC = 1000
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [DIN_N-1:0]      din_in,
    input  logic [AIN_N*AW-1:0]   ain_in,
    output logic [DOUT_N-1:0]     dout_o,
    output logic [AIN_N-1:0]      alarm_o,
    input  logic                  scan_start_in,
    input  logic                  scan_end_in,
    output logic                  scan_done_o,
    input  logic [3:0]            addr_in,
    input  logic                  we_in,
    input  logic [AW-1:0]         wdata_in,
    output logic [AW-1:0]         rdata_o
);

    localparam int c_DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam int c_WDT_W = (WDT_CYC > 1) ? $clog2(WDT_CYC) : 1;
    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEB_CYC - 1);
    localparam logic [c_WDT_W-1:0] c_WDT_LAST = c_WDT_W'(WDT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LATCH  = 2'd1,
        S_ACTIVE = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_trip;
    logic                w_set_ovr;
    logic                w_active;

    logic [DIN_N-1:0]    r_sync1;
    logic [DIN_N-1:0]    r_sync2;
    logic [DIN_N-1:0]    r_deb;
    logic [DIN_N-1:0]    r_in_img;
    logic [AW-1:0]       r_a_img [AIN_N];
    logic [AIN_N-1:0]    r_alarm;
    logic [DOUT_N-1:0]   r_shadow;
    logic [DOUT_N-1:0]   r_dout;
    logic [c_WDT_W-1:0]  r_wdt;
    logic                r_ovr;
    logic                r_trip;
    logic                r_done;
    logic [AW-1:0]       r_rdata;
    logic [AW-1:0]       w_rdata;
    logic                w_wr_shadow;
    logic                w_wr_flags;
    logic                w_unused;

    assign w_active    = (r_state != S_IDLE);
    assign w_wr_shadow = we_in && (addr_in == 4'h1);
    assign w_wr_flags  = we_in && (addr_in == 4'h3);
    assign w_unused    = ^wdata_in;

    // ---------------- input synchroniser ----------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= din_in;
            r_sync2 <= r_sync1;
        end
    end

    // One counter per bit; any sample agreeing with the accepted value restarts it.
    generate
        for (genvar gi = 0; gi < DIN_N; gi++) begin : g_deb
            logic [c_DEB_W-1:0] r_cnt;
            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    r_cnt     <= '0;
                    r_deb[gi] <= 1'b0;
                end else if (r_sync2[gi] != r_deb[gi]) begin
                    if (r_cnt == c_DEB_LAST) begin
                        r_cnt     <= '0;
                        r_deb[gi] <= r_sync2[gi];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end
    endgenerate

    // ---------------- scan FSM ----------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_trip    = 1'b0;
        w_set_ovr = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (scan_start_in) begin
                    w_next = S_LATCH;
                end
            end
            S_LATCH: begin
                w_next = S_ACTIVE;
            end
            S_ACTIVE: begin
                w_set_ovr = scan_start_in;
                if (scan_end_in) begin
                    w_next = S_COMMIT;
                end else if (r_wdt == c_WDT_LAST) begin
                    w_trip = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ---------------- images, outputs, flags ----------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_in_img <= '0;
            for (int k = 0; k < AIN_N; k++) begin
                r_a_img[k] <= '0;
            end
            r_alarm  <= '0;
            r_shadow <= '0;
            r_dout   <= '0;
            r_wdt    <= '0;
            r_ovr    <= 1'b0;
            r_trip   <= 1'b0;
            r_done   <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (r_state == S_LATCH) begin
                r_in_img <= r_deb;
                r_wdt    <= '0;
                for (int k = 0; k < AIN_N; k++) begin
                    r_a_img[k] <= ain_in[k*AW +: AW];
                    if (ain_in[k*AW +: AW] >= HI_LIM) begin
                        r_alarm[k] <= 1'b1;
                    end else if (ain_in[k*AW +: AW] <= LO_LIM) begin
                        r_alarm[k] <= 1'b0;
                    end
                end
            end else if (r_state == S_ACTIVE) begin
                r_wdt <= r_wdt + 1'b1;
            end

            // A trip overrides both a pending commit and a same-cycle shadow write.
            if (w_trip) begin
                r_shadow <= '0;
                r_dout   <= '0;
            end else begin
                if (w_wr_shadow) begin
                    r_shadow <= wdata_in[DOUT_N-1:0];
                end
                if (r_state == S_COMMIT) begin
                    r_dout <= r_shadow;
                end
            end

            if (w_set_ovr) begin
                r_ovr <= 1'b1;
            end else if (w_wr_flags && wdata_in[1]) begin
                r_ovr <= 1'b0;
            end

            if (w_trip) begin
                r_trip <= 1'b1;
            end else if (w_wr_flags && wdata_in[2]) begin
                r_trip <= 1'b0;
            end

            r_done  <= (r_state == S_COMMIT);
            r_rdata <= w_rdata;
        end
    end

    // ---------------- register read mux ----------------
    always_comb begin
        w_rdata = '0;
        case (addr_in)
            4'h0: w_rdata[DIN_N-1:0]  = r_in_img;
            4'h1: w_rdata[DOUT_N-1:0] = r_shadow;
            4'h2: w_rdata[DOUT_N-1:0] = r_dout;
            4'h3: w_rdata[2:0]        = {r_trip, r_ovr, w_active};
            4'h8: w_rdata[AIN_N-1:0]  = r_alarm;
            default: w_rdata = '0;
        endcase
        for (int k = 0; k < AIN_N; k++) begin
            if (addr_in == 4'(4 + k)) begin
                w_rdata = r_a_img[k];
            end
        end
    end

    assign dout_o      = r_dout;
    assign alarm_o     = r_alarm;
    assign scan_done_o = r_done;
    assign rdata_o     = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_plc_io_scan.sv
// ============================================================================
// Module   : tb_plc_io_scan
// Purpose  : Self-checking bench for plc_io_scan with a scan-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_plc_io_scan;

    localparam int          DIN_N   = 4;
    localparam int          DOUT_N  = 4;
    localparam int          AIN_N   = 1;
    localparam int          AW      = 16;
    localparam int          DEB_CYC = 4;
    localparam int          WDT_CYC = 20;
    localparam logic [15:0] HI      = 16'd100;
    localparam logic [15:0] LO      = 16'd90;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [DIN_N-1:0]     din = '0;
    logic [AIN_N*AW-1:0]  ain = '0;
    logic [DOUT_N-1:0]    dout;
    logic [AIN_N-1:0]     alarm;
    logic                 start = 1'b0;
    logic                 stop  = 1'b0;
    logic                 done;
    logic [3:0]           addr  = '0;
    logic                 we    = 1'b0;
    logic [AW-1:0]        wdata = '0;
    logic [AW-1:0]        rdata;

    int n_chk    = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    // Reference state, updated only at scan-level events.
    logic [DOUT_N-1:0] m_shadow = '0;
    logic [DOUT_N-1:0] m_dout   = '0;
    logic              m_alarm  = 1'b0;

    plc_io_scan #(
        .DIN_N(DIN_N), .DOUT_N(DOUT_N), .AIN_N(AIN_N), .AW(AW),
        .DEB_CYC(DEB_CYC), .HI_LIM(HI), .LO_LIM(LO), .WDT_CYC(WDT_CYC)
    ) dut (
        .clk_in(clk), .rst_in(rst), .din_in(din), .ain_in(ain),
        .dout_o(dout), .alarm_o(alarm),
        .scan_start_in(start), .scan_end_in(stop), .scan_done_o(done),
        .addr_in(addr), .we_in(we), .wdata_in(wdata), .rdata_o(rdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "simulation timeout");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [15:0] exp);
        addr = a;
        we   = 1'b0;
        step(1);
        chk(tag, 32'(rdata), 32'(exp));
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        step(1);
        we    = 1'b0;
    endtask

    // Returns in the first ACTIVE cycle, images already frozen.
    task automatic begin_scan();
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        if (ain[15:0] >= HI)      m_alarm = 1'b1;
        else if (ain[15:0] <= LO) m_alarm = 1'b0;
        chk("alarm_at_latch", 32'(alarm), 32'(m_alarm));
    endtask

    task automatic end_scan();
        int d0;
        d0   = done_cnt;
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("dout_before_commit", 32'(dout), 32'(m_dout));
        step(1);
        m_dout = m_shadow;
        chk("dout_after_commit", 32'(dout), 32'(m_dout));
        chk("done_high", 32'(done), 32'd1);
        step(1);
        chk("done_single_pulse", 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        int          samp [5];
        logic        exp_al [5];
        int          d0;
        logic [3:0]  dv;
        logic [15:0] w;

        samp   = '{95, 100, 95, 90, 95};
        exp_al = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset then idle
        step(1);
        rst = 1'b0;
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_alarm", 32'(alarm), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        for (int a = 0; a < 16; a++) begin
            rd_chk($sformatf("rst_reg%0h", a), 4'(a), 16'h0000);
        end

        // Debounce latency: latch edge one cycle before acceptance sees 0
        step(10);
        din[0] = 1'b1;
        step(4);
        begin_scan();
        rd_chk("deb_not_yet", 4'h0, 16'h0000);
        end_scan();
        din[0] = 1'b0;
        step(12);
        din[0] = 1'b1;
        step(5);
        begin_scan();
        rd_chk("deb_accepted", 4'h0, 16'h0001);
        end_scan();

        // Short pulses on din[1] are never accepted
        din[1] = 1'b1; step(3);
        din[1] = 1'b0; step(1);
        din[1] = 1'b1; step(3);
        din[1] = 1'b0; step(10);
        begin_scan();
        rd_chk("glitch_rejected", 4'h0, 16'h0001);
        end_scan();

        // Scan-end outside a scan is ignored
        d0 = done_cnt;
        stop = 1'b1; step(1); stop = 1'b0; step(2);
        chk("idle_end_ignored", 32'(done_cnt - d0), 32'd0);

        // Scan round-trip
        din = 4'b0010;
        ain = 16'd5;
        step(8);
        begin_scan();
        rd_chk("rt_in_img", 4'h0, 16'h0002);
        rd_chk("rt_a_img", 4'h4, 16'd5);
        rd_chk("rt_status", 4'h3, 16'h0001);
        wr(4'h1, 16'h0005);
        m_shadow = 4'h5;
        rd_chk("rt_shadow", 4'h1, 16'h0005);
        chk("rt_dout_held", 32'(dout), 32'd0);
        end_scan();
        chk("rt_dout_pins", 32'(dout), 32'h5);
        rd_chk("rt_dout_reg", 4'h2, 16'h0005);

        // Hysteresis across scans; pin movement mid-scan leaves the image alone
        for (int i = 0; i < 5; i++) begin
            ain = 16'(samp[i]);
            begin_scan();
            chk($sformatf("hyst_alarm%0d", i), 32'(alarm), 32'(exp_al[i]));
            ain = 16'd200;
            step(2);
            rd_chk($sformatf("hyst_img%0d", i), 4'h4, 16'(samp[i]));
            rd_chk($sformatf("hyst_reg%0d", i), 4'h8, 16'(exp_al[i]));
            end_scan();
        end

        // Overrun: stray start while active, then start+end together
        begin_scan();
        start = 1'b1; step(1); start = 1'b0;
        rd_chk("ovr_set", 4'h3, 16'h0003);
        wr(4'h3, 16'h0002);
        rd_chk("ovr_cleared", 4'h3, 16'h0001);
        // set event beats same-cycle clear
        start = 1'b1; addr = 4'h3; wdata = 16'h0002; we = 1'b1;
        step(1);
        start = 1'b0; we = 1'b0;
        rd_chk("ovr_set_wins", 4'h3, 16'h0003);
        wr(4'h3, 16'h0002);
        d0 = done_cnt;
        start = 1'b1; stop = 1'b1;
        step(1);
        start = 1'b0; stop = 1'b0;
        step(2);
        chk("both_commit_done", 32'(done_cnt - d0), 32'd1);
        m_dout = m_shadow;
        chk("both_commit_dout", 32'(dout), 32'(m_dout));
        rd_chk("both_ovr", 4'h3, 16'h0002);
        wr(4'h3, 16'h0002);
        rd_chk("ovr_w1c", 4'h3, 16'h0000);

        // Watchdog
        begin_scan();
        wr(4'h1, 16'h000F);
        m_shadow = 4'hF;
        end_scan();
        chk("wdt_pre_dout", 32'(dout), 32'hF);
        d0 = done_cnt;
        begin_scan();
        step(19);
        chk("wdt_not_yet", 32'(dout), 32'hF);
        addr = 4'h1; wdata = 16'h000A; we = 1'b1;
        step(1);
        we = 1'b0;
        m_dout = '0;
        m_shadow = '0;
        chk("wdt_dout_safe", 32'(dout), 32'd0);
        rd_chk("wdt_shadow_cleared", 4'h1, 16'h0000);
        rd_chk("wdt_flag_idle", 4'h3, 16'h0004);
        chk("wdt_no_done", 32'(done_cnt - d0), 32'd0);
        wr(4'h3, 16'h0004);
        rd_chk("wdt_w1c", 4'h3, 16'h0000);

        // Reset in the middle of a scan
        ain = 16'd200;
        begin_scan();
        wr(4'h1, 16'h0003);
        m_shadow = 4'h3;
        end_scan();
        begin_scan();
        start = 1'b1; step(1); start = 1'b0;
        rst = 1'b1; step(1); rst = 1'b0;
        m_alarm = 1'b0; m_dout = '0; m_shadow = '0;
        chk("mid_rst_dout", 32'(dout), 32'd0);
        chk("mid_rst_alarm", 32'(alarm), 32'd0);
        rd_chk("mid_rst_status", 4'h3, 16'h0000);
        rd_chk("mid_rst_shadow", 4'h1, 16'h0000);
        rd_chk("mid_rst_aimg", 4'h4, 16'h0000);

        // Randomised scans against the reference model
        for (int i = 0; i < 12; i++) begin
            dv  = 4'($urandom_range(0, 15));
            din = dv;
            ain = 16'($urandom_range(80, 110));
            step(8);
            begin_scan();
            rd_chk("rnd_in_img", 4'h0, 16'(dv));
            rd_chk("rnd_a_img", 4'h4, ain[15:0]);
            rd_chk("rnd_alarm", 4'h8, 16'(m_alarm));
            w = 16'($urandom);
            wr(4'h1, w);
            m_shadow = w[3:0];
            wr(4'h2, 16'($urandom));
            rd_chk("rnd_dout_ro", 4'h2, 16'(m_dout));
            end_scan();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/plc_io_scan.md
Name: plc_io_scan

Overview:
- Parametrised PLC I/O image block between the uP core and the field pins: analog channels (pressure-type) and N digital inputs/outputs (start/stop/motor/max-type).
- Debounces digital inputs. Freezes input and analog images at scan start; the uP reads them over a small register port.
- Outputs are double-buffered: writes go to a shadow register, which is committed to the pins at scan end.
- A scan watchdog forces the outputs to a safe state if the program stalls.

Parameters:
- DIN_N, 4, number of digital inputs (1..16)
- DOUT_N, 4, number of digital outputs (1..16)
- AIN_N, 1, number of analog inputs (1..4)
- AW, 16, analog sample and register data width
- DEB_CYC, 4, consecutive stable cycles required to accept a digital input change (>=1)
- HI_LIM, 16'd100, analog alarm set threshold (unsigned)
- LO_LIM, 16'd90, analog alarm clear threshold (LO_LIM < HI_LIM)
- WDT_CYC, 1000, maximum cycles in ACTIVE before a watchdog trip

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- din_in  in  DIN_N  raw asynchronous digital inputs
- ain_in  in  AIN_N*AW  analog samples, channel k at bits [k*AW +: AW]
- dout_o  out  DOUT_N  committed digital outputs to pins
- alarm_o  out  AIN_N  per-channel analog hysteresis alarm
- scan_start_in  in  1  1-cycle pulse from the uP: begin scan
- scan_end_in  in  1  1-cycle pulse from the uP: end scan, commit outputs
- scan_done_o  out  1  1-cycle pulse after a commit
- addr_in  in  4  register address
- we_in  in  1  register write enable
- wdata_in  in  AW  write data
- rdata_o  out  AW  read data, registered

Behaviour:
- Reset (synchronous, active-high) forces:
  - dout_o=0, alarm_o=0, scan_done_o=0, rdata_o=0
  - all images, the shadow register and the debounce state to 0
  - overrun and wdt_trip flags to 0; FSM to IDLE
- Digital input path:
  - Each din_in bit passes through a 2-FF synchroniser, then a per-bit counter.
  - The debounced value changes only after the synchronised value has differed from it for DEB_CYC consecutive cycles.
  - Any glitch shorter than that resets the counter.
  - Latency from a pin change to a debounced change is 2+DEB_CYC cycles.
- FSM states and transitions:
  - IDLE: scan_start_in -> LATCH. scan_end_in is ignored.
  - LATCH (1 cycle): in_img <= debounced inputs; a_img[k] <= ain_in[k]; alarm update; watchdog counter cleared -> ACTIVE.
  - ACTIVE: watchdog counter increments each cycle.
    - scan_end_in -> COMMIT.
    - scan_start_in sets the sticky overrun flag and is otherwise ignored.
    - Both pulses in the same cycle: the end is honoured and overrun is set.
    - Counter reaching WDT_CYC with no scan_end_in: dout_o <= 0, shadow <= 0, wdt_trip <= 1 -> IDLE. scan_done_o is not pulsed.
  - COMMIT (1 cycle): dout_o <= shadow (value before any same-cycle write) -> IDLE. scan_done_o is high in the following cycle.
- Alarm, evaluated only in LATCH, per channel:
  - a_img >= HI_LIM sets the alarm.
  - a_img <= LO_LIM clears it.
  - Otherwise the alarm holds.
  - The comparison is unsigned, full AW width.
- Register map (unused high bits read 0; unmapped addresses read 0; writes to read-only addresses are ignored):
  - 0x0 R: in_img, zero-extended
  - 0x1 R/W: output shadow [DOUT_N-1:0]. Writable in any state, except the same cycle as a watchdog trip (trip wins).
  - 0x2 R: dout_o
  - 0x3 R/W1C: {.., wdt_trip[2], overrun[1], scan_active[0]}. Writing 1 to bit 1 or 2 clears that flag. A set event in the same cycle as a clear wins.
  - 0x4+k R: a_img[k] for k < AIN_N
  - 0x8 R: alarm_o, zero-extended
- Reads: rdata_o reflects addr_in one cycle later, sampled with the register values of the request cycle.
- scan_active is 1 in LATCH, ACTIVE and COMMIT.
- Images are stable during ACTIVE regardless of pin activity.

Test Plan:
- Reset then idle: after rst_in has been high for 1 cycle, dout_o=0, alarm_o=0, every register address reads 0.
- Debounce: din_in[0] rises and holds (DEB_CYC=4) -> the debounced bit is 1 exactly 6 cycles later. A 3-cycle pulse on din_in[1] -> never accepted.
- Scan round-trip:
  - Pulse start; ain_in=5; din_in=4'b0010 held >6 cycles beforehand.
  - Read 0x0=0x0002 and 0x4=5; write 0x1=0x5; pulse end.
  - dout_o=4'b0101 the cycle after COMMIT; scan_done_o pulses once.
- Hysteresis across scans:
  - Samples 95, 100, 95, 90, 95 give alarm 0, 1, 1, 0, 0.
  - The pin changing mid-scan (ACTIVE) does not alter 0x4.
- Overrun/simultaneous: start pulse during ACTIVE -> 0x3 bit1=1 and the FSM stays ACTIVE. Start+end in the same cycle -> commit occurs and overrun=1. Write 0x3=0x2 -> bit1 cleared.
- Watchdog: WDT_CYC=20, dout_o=4'b1111 committed, then start with no end -> after 20 ACTIVE cycles dout_o=0, 0x3 bit2=1, FSM IDLE, no scan_done_o. Reset mid-ACTIVE -> immediate IDLE with all flags cleared.
